// File: rtl/mips_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dmem_ctrl
//  Description : Multi-cycle data-memory stage for the MIPS datapath. It is a
//                word-organised RAM that stalls the CPU until each access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  memread,
    input  logic                  memwrite,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  stall,
    output logic                  misalign_err,
    output logic [CNT_WIDTH-1:0]  acc_count
);

    localparam int         c_IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_write;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_misalign;
    logic [CNT_WIDTH-1:0]  r_acc_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_aligned;
    logic                  w_start;
    logic                  w_misalign_hit;
    logic                  w_commit;
    logic                  w_stall;
    logic                  w_unused_addr_hi;

    assign w_req     = memread | memwrite;
    assign w_aligned = (addr[1:0] == 2'b00);

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH words.
    assign w_unused_addr_hi = ^addr[DATA_WIDTH-1:c_IDX_W+2];

    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_misalign_hit = 1'b0;
        w_commit       = 1'b0;
        w_stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_aligned) begin
                        w_start     = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_misalign_hit = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_wait_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            // The request still visible here belongs to the instruction just served.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stall is masked by reset so an aborted access releases the CPU at once.
    assign stall = w_stall & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_readdata  <= '0;
            r_misalign  <= 1'b0;
            r_acc_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_wait_cnt <= c_WAIT_INIT;
                r_idx      <= addr[c_IDX_W+1:2];
                r_wdata    <= wdata;
                r_is_write <= memwrite;
            end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_misalign_hit) begin
                r_misalign <= 1'b1;
            end
            if (w_commit) begin
                r_acc_count <= r_acc_count + CNT_WIDTH'(1);
                if (!r_is_write) begin
                    r_readdata <= r_mem[r_idx];
                end
            end
        end
    end

    // RAM contents survive reset; commit is driven from the reset-cleared FSM.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign readdata     = r_readdata;
    assign misalign_err = r_misalign;
    assign acc_count    = r_acc_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_dmem_ctrl
//  Description : Directed, table-driven bench for mips_dmem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_ctrl;

    localparam int c_LAT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign_err;
    logic [15:0] acc_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [11];

    mips_dmem_ctrl #(
        .DATA_WIDTH (32),
        .DEPTH      (64),
        .LATENCY    (c_LAT),
        .CNT_WIDTH  (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .memread      (memread),
        .memwrite     (memwrite),
        .readdata     (readdata),
        .stall        (stall),
        .misalign_err (misalign_err),
        .acc_count    (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access: hold the request until stall drops, then one more edge.
    task automatic access(input int id, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic [15:0] exp_cnt,
                          input logic exp_mis);
        int stalls;
        int exp_stalls;
        stalls     = 0;
        exp_stalls = (a[1:0] == 2'b00) ? c_LAT + 1 : 0;
        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = d;
        #1;
        while (stall && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check($sformatf("v%0d_stall_cycles", id), 32'(stalls), 32'(exp_stalls));
        if (rd && !wr && exp_stalls != 0)
            check($sformatf("v%0d_readdata_done", id), readdata, exp_rd);
        @(posedge clk);
        #1;
        memread = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        #1;
        check($sformatf("v%0d_readdata", id), readdata, exp_rd);
        check($sformatf("v%0d_acc_count", id), 32'(acc_count), 32'(exp_cnt));
        check($sformatf("v%0d_misalign", id), 32'(misalign_err), 32'(exp_mis));
        check($sformatf("v%0d_stall_idle", id), 32'(stall), 32'd0);
    endtask

    initial begin
        //            rd    wr    addr          wdata          exp_rd        cnt    mis
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 16'd1,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 16'd2,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hDEAD_BEEF, 16'd3,  1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 16'd4,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 16'd5,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 16'd6,  1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hCAFE_F00D, 16'd6,  1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'hCAFE_F00D, 16'd7,  1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hA5A5_A5A5, 16'd8,  1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0001, 32'hA5A5_A5A5, 16'd9,  1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h0000_0001, 16'd10, 1'b1};

        rst = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle%0d_stall", c),    32'(stall),        32'd0);
            check($sformatf("idle%0d_readdata", c), readdata,          32'd0);
            check($sformatf("idle%0d_misalign", c), 32'(misalign_err), 32'd0);
            check($sformatf("idle%0d_acc", c),      32'(acc_count),    32'd0);
        end

        for (int i = 0; i < 11; i++)
            access(i, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                   vecs[i].exp_rd, vecs[i].exp_cnt, vecs[i].exp_mis);

        // Reset lands in the first WAIT cycle of a store to 0x30.
        @(negedge clk);
        memwrite = 1'b1; addr = 32'h0000_0030; wdata = 32'hFFFF_FFFF;
        #1;
        check("abort_start_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        check("abort_wait_stall", 32'(stall), 32'd1);
        rst = 1'b1; memwrite = 1'b0;
        #1;
        check("abort_stall",    32'(stall),        32'd0);
        check("abort_acc",      32'(acc_count),    32'd0);
        check("abort_misalign", 32'(misalign_err), 32'd0);
        check("abort_readdata", readdata,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_post_stall", 32'(stall), 32'd0);
        access(11, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0001, 16'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
